hazard_tnew_tracker: RTL
========================

HAZARD_TNEW_TRACKER -- requirements
Module: hazard_tnew_tracker

Interface
REQ-001 SHALL have parameter STAGES, default 3, number of tracked post-decode stages (stage 0 = E, 1 = M, 2 = W); legal range 2..8.
REQ-002 SHALL have parameter AW, default 5, register-address width.
REQ-003 SHALL have parameter TW, default 2, Tnew/Tuse width; Tuse value all-ones means "source not used".
REQ-004 SHALL have parameter SW, default 4, forwarding-select width; SW >= clog2(STAGES+1).
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 d_valid  input  1  a valid instruction sits in D.
REQ-008 d_rs, d_rt  input  AW each  D-stage source register numbers.
REQ-009 d_tuse_rs, d_tuse_rt  input  TW each  cycles until each source is consumed.
REQ-010 d_we  input  1  D instruction writes a register.
REQ-011 d_dst  input  AW  D instruction destination register.
REQ-012 d_tnew  input  TW  producer latency, valid on entry to stage 0.
REQ-013 stall  output  1  freeze F/D and insert a bubble into stage 0.
REQ-014 fwd_rs, fwd_rt  output  SW each  D-stage forward source: 0 = register file, k = stage k-1.
REQ-015 stall_cnt  output  16  saturating count of stalled cycles.

Function
REQ-016 Each stage i SHALL hold {valid, dst, tnew}; an entry with dst = 0 or valid = 0 SHALL never match.
REQ-017 Each cycle, stage 0 SHALL load {1, d_dst, d_tnew} when d_valid & d_we & !stall, else a bubble (valid = 0).
REQ-018 Stage i>0 SHALL load stage i-1 with tnew decremented by 1, saturating at 0; the last stage's entry retires.
REQ-019 Per source (rs, rt): match = youngest stage (lowest i) with valid & dst == src & src != 0; older matches ignored.
REQ-020 stall SHALL be combinational: d_valid & any source with tuse != all-ones whose match has tnew > tuse.
REQ-021 fwd_x SHALL equal match index + 1 when the match has tnew = 0, else 0; fwd_x SHALL be 0 when the source is unused or unmatched.
REQ-022 stall_cnt SHALL increment by 1 each cycle stall = 1, holding at 0xFFFF.
REQ-023 Tracker state SHALL NOT change when d_valid = 0 other than normal advance and bubble insertion.

Reset
REQ-024 While reset = 0 at a clock edge, all stage valid bits, dst and tnew SHALL clear to 0 and stall_cnt SHALL clear to 0.
REQ-025 After reset, stall = 0, fwd_rs = fwd_rt = 0 regardless of D inputs until a producer enters stage 0.
REQ-026 Reset asserted mid-stall SHALL discard all in-flight entries; no stall carries across reset.

Configuration
REQ-027 Macro HAZARD_TNEW_FWD_EN defined: forwarding per REQ-020/REQ-021.
REQ-028 HAZARD_TNEW_FWD_EN undefined: fwd_rs = fwd_rt = 0 constantly; stall = 1 whenever a used source matches any stage 0..STAGES-2 (last stage writes the register file with internal bypass), Tnew/Tuse ignored.

Verification (STAGES=3, FWD_EN defined unless noted)
REQ-029 addu $3 (tnew=1) then beq using $3 (tuse_rs=0) -> stall = 1 for one cycle, next cycle stall = 0, fwd_rs = 2.
REQ-030 lw $4 (tnew=2) then addu using $4 (tuse=1) -> stall = 1 for one cycle, then stall = 0, fwd_rs = 0; stall_cnt = 1.
REQ-031 Producer with d_dst = 0, d_tnew = 2 followed by consumer of $0 with tuse=0 -> stall = 0, fwd = 0.
REQ-032 $5 written in stage 1 (tnew=0) and stage 0 (tnew=1), consumer tuse=0 -> youngest wins: stall = 1, then fwd_rs = 2.
REQ-033 reset = 0 during the stall of REQ-030 -> next cycle stall = 0, stall_cnt = 0, all fwd = 0.
REQ-034 FWD_EN undefined: addu $6 then addu using $6 (tuse=1) -> stall = 1 for two cycles, then stall = 0, fwd_rs = 0.

Source files
------------

// File: rtl/hazard_tnew_tracker_if.sv
// ---------------------------------------------------------------------------
// hazard_tnew_tracker_if
//
// Purpose: groups the D-stage instruction description and the hazard
// responses exchanged between a pipeline front end (master) and the
// hazard_tnew_tracker (slave).
//
// Signals:
//   d_valid            master->slave  a valid instruction sits in D
//   d_rs, d_rt         master->slave  D-stage source register numbers
//   d_tuse_rs/rt       master->slave  cycles until each source is consumed;
//                                     all-ones marks the source as unused
//   d_we               master->slave  D instruction writes a register
//   d_dst              master->slave  D instruction destination register
//   d_tnew             master->slave  producer latency on entry to stage 0
//   stall              slave->master  freeze F/D, bubble into stage 0
//   fwd_rs, fwd_rt     slave->master  0 = register file, k = stage k-1
//   stall_cnt          slave->master  saturating count of stalled cycles
// ---------------------------------------------------------------------------
interface hazard_tnew_tracker_if #(
  parameter int AW = 5,
  parameter int TW = 2,
  parameter int SW = 4
);
  logic          d_valid;
  logic [AW-1:0] d_rs;
  logic [AW-1:0] d_rt;
  logic [TW-1:0] d_tuse_rs;
  logic [TW-1:0] d_tuse_rt;
  logic          d_we;
  logic [AW-1:0] d_dst;
  logic [TW-1:0] d_tnew;
  logic          stall;
  logic [SW-1:0] fwd_rs;
  logic [SW-1:0] fwd_rt;
  logic [15:0]   stall_cnt;

  modport master (
    output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_we, d_dst, d_tnew,
    input  stall, fwd_rs, fwd_rt, stall_cnt
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_we, d_dst, d_tnew,
    output stall, fwd_rs, fwd_rt, stall_cnt
  );
endinterface

// File: rtl/hazard_tnew_tracker.sv
// ---------------------------------------------------------------------------
// hazard_tnew_tracker
//
// Purpose: Tnew/Tuse data-hazard unit for an in-order pipeline. Tracks the
// destination register and remaining producer latency (Tnew) of every
// instruction in the post-decode stages (stage 0 = E, 1 = M, 2 = W, ...),
// compares them against the D-stage sources, and produces a stall request
// plus a forwarding select for each source.
//
// Ports:
//   clk    in   single clock, all state changes on the rising edge
//   reset  in   synchronous, active-low reset
//   bus    slave modport of hazard_tnew_tracker_if (D-stage inputs,
//               stall / fwd_rs / fwd_rt / stall_cnt outputs)
//
// Parameters:
//   STAGES  tracked post-decode stages, legal range 2..8
//   AW      register-address width
//   TW      Tnew/Tuse width (Tuse all-ones = source not used)
//   SW      forwarding-select width, at least clog2(STAGES+1)
//
// Configuration macro: HAZARD_TNEW_FWD_EN
//   defined   : full forwarding; stall only when the youngest matching
//               producer cannot deliver its value before the consumer needs
//               it (Tnew > Tuse), otherwise forward from the matching stage.
//   undefined : no forwarding network; any used source that matches a
//               stage 0..STAGES-2 stalls (the last stage writes the register
//               file with an internal bypass). Tnew/Tuse values are ignored
//               apart from the "unused" encoding.
// ---------------------------------------------------------------------------
module hazard_tnew_tracker #(
  parameter int STAGES = 3,
  parameter int AW     = 5,
  parameter int TW     = 2,
  parameter int SW     = 4
) (
  input  logic           clk,
  input  logic           reset,
  hazard_tnew_tracker_if.slave bus
);

  localparam logic [TW-1:0] TUSE_NONE = '1;

  // Tnew counts down as the producer advances; once its result exists it
  // stays available, so the count floors at zero.
  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] v);
    return (v == '0) ? '0 : v - TW'(1);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stage entries: stage 0 is the youngest instruction past D.
  logic          r_stg_vld  [STAGES];
  logic [AW-1:0] r_stg_dst  [STAGES];
  logic [TW-1:0] r_stg_tnew [STAGES];
  logic [15:0]   r_stall_cnt;

  logic          w_stall;
  logic          w_load;
  logic          w_rs_used;
  logic          w_rt_used;
  logic [SW-1:0] w_fwd_rs;
  logic [SW-1:0] w_fwd_rt;

  assign w_rs_used = (bus.d_tuse_rs != TUSE_NONE);
  assign w_rt_used = (bus.d_tuse_rt != TUSE_NONE);

`ifdef HAZARD_TNEW_FWD_EN
  logic          w_rs_hit;
  logic          w_rt_hit;
  logic [SW-1:0] w_rs_idx;
  logic [SW-1:0] w_rt_idx;
  logic [TW-1:0] w_rs_tnew;
  logic [TW-1:0] w_rt_tnew;
  logic          w_rs_stall;
  logic          w_rt_stall;

  // Scan from oldest to youngest so that the youngest match overwrites any
  // older one: only the most recent writer of a register is relevant.
  always_comb begin
    w_rs_hit  = 1'b0;
    w_rs_idx  = '0;
    w_rs_tnew = '0;
    w_rt_hit  = 1'b0;
    w_rt_idx  = '0;
    w_rt_tnew = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (r_stg_vld[i] && (bus.d_rs != '0) && (r_stg_dst[i] == bus.d_rs)) begin
        w_rs_hit  = 1'b1;
        w_rs_idx  = SW'(i);
        w_rs_tnew = r_stg_tnew[i];
      end
      if (r_stg_vld[i] && (bus.d_rt != '0) && (r_stg_dst[i] == bus.d_rt)) begin
        w_rt_hit  = 1'b1;
        w_rt_idx  = SW'(i);
        w_rt_tnew = r_stg_tnew[i];
      end
    end
  end

  assign w_rs_stall = w_rs_used && w_rs_hit && (w_rs_tnew > bus.d_tuse_rs);
  assign w_rt_stall = w_rt_used && w_rt_hit && (w_rt_tnew > bus.d_tuse_rt);
  assign w_stall    = bus.d_valid && (w_rs_stall || w_rt_stall);

  // Forward only once the producer's result exists (Tnew reached 0);
  // select k means "take the value held in stage k-1".
  assign w_fwd_rs = (w_rs_used && w_rs_hit && (w_rs_tnew == '0)) ?
                    (w_rs_idx + SW'(1)) : '0;
  assign w_fwd_rt = (w_rt_used && w_rt_hit && (w_rt_tnew == '0)) ?
                    (w_rt_idx + SW'(1)) : '0;
`else
  logic w_rs_hit;
  logic w_rt_hit;

  // Without forwarding the value only becomes visible through the register
  // file, which the last stage writes with an internal bypass, so every
  // stage except the last blocks a dependent consumer.
  always_comb begin
    w_rs_hit = 1'b0;
    w_rt_hit = 1'b0;
    for (int i = 0; i < STAGES - 1; i++) begin
      if (r_stg_vld[i] && (bus.d_rs != '0) && (r_stg_dst[i] == bus.d_rs)) begin
        w_rs_hit = 1'b1;
      end
      if (r_stg_vld[i] && (bus.d_rt != '0) && (r_stg_dst[i] == bus.d_rt)) begin
        w_rt_hit = 1'b1;
      end
    end
  end

  assign w_stall  = bus.d_valid && ((w_rs_used && w_rs_hit) ||
                                    (w_rt_used && w_rt_hit));
  assign w_fwd_rs = '0;
  assign w_fwd_rt = '0;
`endif

  // A stalled D instruction must not enter stage 0; a bubble goes in instead.
  assign w_load = bus.d_valid && bus.d_we && !w_stall;

  // ---- D -> stage 0 -> ... -> stage STAGES-1 ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) begin
        r_stg_vld[i]  <= 1'b0;
        r_stg_dst[i]  <= '0;
        r_stg_tnew[i] <= '0;
      end
      r_stall_cnt <= 16'd0;
    end else begin
      r_stg_vld[0]  <= w_load;
      r_stg_dst[0]  <= w_load ? bus.d_dst  : '0;
      r_stg_tnew[0] <= w_load ? bus.d_tnew : '0;
      for (int i = 1; i < STAGES; i++) begin
        r_stg_vld[i]  <= r_stg_vld[i-1];
        r_stg_dst[i]  <= r_stg_dst[i-1];
        r_stg_tnew[i] <= sat_dec(r_stg_tnew[i-1]);
      end
      if (w_stall) begin
        r_stall_cnt <= sat_inc16(r_stall_cnt);
      end
    end
  end

  assign bus.stall     = w_stall;
  assign bus.fwd_rs    = w_fwd_rs;
  assign bus.fwd_rt    = w_fwd_rt;
  assign bus.stall_cnt = r_stall_cnt;

endmodule
